// File: rtl/mu0_cpu_delay1_if.sv
// Word-addressed RAM bus between the MU0 CPU (master) and its single-port RAM (slave).
interface mu0_cpu_delay1_if;
    logic [11:0] address;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/mu0_cpu_delay1.sv
// Multicycle MU0 accumulator CPU driving a one-cycle-latency 16x4096 RAM.
// Optional LDI instruction (opcode 8) enabled by defining MU0_LDI_EN.
module mu0_cpu_delay1 #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              running,
    mu0_cpu_delay1_if.master  bus
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

    state_t      state_reg;
    logic [11:0] pc_reg;
    logic [15:0] acc_reg;
    logic [3:0]  op_reg;
    logic        running_reg;

    // The instruction is decoded straight off readdata in EXEC; there is no IR.
    logic [3:0]  opcode;
    logic [11:0] s_field;
    assign opcode  = bus.readdata[15:12];
    assign s_field = bus.readdata[11:0];

    assign running       = running_reg;
    assign bus.writedata = acc_reg;

    // Strobes are gated by rst so a pending STA write is dropped the moment reset rises.
    always_comb begin
        bus.address = pc_reg;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        if (!rst) begin
            case (state_reg)
                FETCH: bus.read = 1'b1;
                EXEC: begin
                    case (opcode)
                        4'h0, 4'h2, 4'h3: begin
                            bus.address = s_field;
                            bus.read    = 1'b1;
                        end
                        4'h1: begin
                            bus.address = s_field;
                            bus.write   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            acc_reg     <= 16'h0000;
            op_reg      <= 4'h0;
            running_reg <= 1'b1;
        end else begin
            case (state_reg)
                FETCH: begin
                    pc_reg    <= pc_reg + 12'd1;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    op_reg    <= opcode;
                    state_reg <= FETCH;
                    case (opcode)
                        4'h0, 4'h2, 4'h3: state_reg <= MEM;
                        4'h4: pc_reg <= s_field;
                        4'h5: if (!acc_reg[15]) pc_reg <= s_field;
                        4'h6: if (acc_reg != 16'h0000) pc_reg <= s_field;
                        4'h7: begin
                            state_reg   <= HALTED;
                            running_reg <= 1'b0;
                        end
`ifdef MU0_LDI_EN
                        4'h8: acc_reg <= {4'b0000, s_field};
`endif
                        default: ;
                    endcase
                end
                MEM: begin
                    // op_reg remembers which operand instruction this read belongs to.
                    case (op_reg)
                        4'h0:    acc_reg <= bus.readdata;
                        4'h2:    acc_reg <= acc_reg + bus.readdata;
                        4'h3:    acc_reg <= acc_reg - bus.readdata;
                        default: ;
                    endcase
                    state_reg <= FETCH;
                end
                HALTED: state_reg <= HALTED;
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_cpu_delay1.sv
// Bench for mu0_cpu_delay1: table vectors, hand sequences and random programs vs an ISA model.
module tb_mu0_cpu_delay1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic running;
    logic load = 1'b0;

    mu0_cpu_delay1_if bus();

    mu0_cpu_delay1 dut (
        .clk     (clk),
        .rst     (rst),
        .running (running),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] img     [4096];
    logic [15:0] ram     [4096];
    logic [15:0] exp_mem [4096];

    // RAM: registered read, write at the edge; load copies the program image in.
    always @(posedge clk) begin
        if (load) begin
            ram          <= img;
            bus.readdata <= 16'h0000;
        end else begin
            if (bus.write) ram[bus.address] <= bus.writedata;
            if (bus.read)  bus.readdata     <= ram[bus.address];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        run;
        logic [11:0] addr;
        logic [15:0] wd;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic cyc_t mk(logic rd, logic wr, logic run, logic [11:0] a, logic [15:0] wd);
        cyc_t c;
        c.rd   = rd;
        c.wr   = wr;
        c.run  = run;
        c.addr = a;
        c.wd   = wr ? wd : 16'h0000;
        return c;
    endfunction

    // Instruction-level model: walks the program and lists the bus activity of every cycle.
    task automatic model_run(output bit halted);
        logic [11:0] pc;
        logic [15:0] acc;
        logic [15:0] ir;
        logic [11:0] s;
        exp_q.delete();
        exp_mem = img;
        pc = 12'h000;
        acc = 16'h0000;
        halted = 1'b0;
        while (!halted && exp_q.size() < 600) begin
            ir = exp_mem[pc];
            s  = ir[11:0];
            exp_q.push_back(mk(1, 0, 1, pc, 0));
            pc = pc + 12'd1;
            case (ir[15:12])
                4'h0, 4'h2, 4'h3: begin
                    exp_q.push_back(mk(1, 0, 1, s, 0));
                    exp_q.push_back(mk(0, 0, 1, pc, 0));
                    if (ir[15:12] == 4'h0) acc = exp_mem[s];
                    else if (ir[15:12] == 4'h2) acc = acc + exp_mem[s];
                    else acc = acc - exp_mem[s];
                end
                4'h1: begin
                    exp_q.push_back(mk(0, 1, 1, s, acc));
                    exp_mem[s] = acc;
                end
                4'h4: begin exp_q.push_back(mk(0, 0, 1, pc, 0)); pc = s; end
                4'h5: begin exp_q.push_back(mk(0, 0, 1, pc, 0)); if ($signed(acc) >= 0) pc = s; end
                4'h6: begin exp_q.push_back(mk(0, 0, 1, pc, 0)); if (acc != 0) pc = s; end
                4'h7: begin
                    exp_q.push_back(mk(0, 0, 1, pc, 0));
                    for (int h = 0; h < 3; h++) exp_q.push_back(mk(0, 0, 0, pc, 0));
                    halted = 1'b1;
                end
`ifdef MU0_LDI_EN
                4'h8: begin exp_q.push_back(mk(0, 0, 1, pc, 0)); acc = {4'h0, s}; end
`endif
                default: exp_q.push_back(mk(0, 0, 1, pc, 0));
            endcase
        end
    endtask

    task automatic clear_img();
        foreach (img[i]) img[i] = 16'h0000;
    endtask

    // Loads img into RAM during a one-cycle reset pulse; returns just after release.
    task automatic load_and_reset();
        rst  = 1'b1;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        n_checks++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 || running !== 1'b1 || bus.address !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got read=%b write=%b running=%b address=%h, want 0 0 1 000",
                     bus.read, bus.write, running, bus.address);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs img, checking every cycle against the model trace and the final memory.
    task automatic run_prog(input string name, output int cycles, output int n_wr,
                            output logic [11:0] wr_addr, output logic [15:0] wr_data,
                            output logic wr_with_read);
        bit   halted;
        cyc_t got;
        cyc_t want;
        int   bad;
        model_run(halted);
        load_and_reset();
        cycles = 0; n_wr = 0; wr_addr = 0; wr_data = 0; wr_with_read = 0;
        #1;
        for (int k = 0; k < exp_q.size(); k++) begin
            got  = mk(bus.read, bus.write, running, bus.address, bus.writedata);
            want = exp_q[k];
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got rd=%b wr=%b run=%b addr=%h wd=%h, want rd=%b wr=%b run=%b addr=%h wd=%h",
                         name, k, got.rd, got.wr, got.run, got.addr, got.wd,
                         want.rd, want.wr, want.run, want.addr, want.wd);
            end
            if (running === 1'b1) cycles++;
            if (bus.write === 1'b1) begin
                n_wr++;
                wr_addr = bus.address;
                wr_data = bus.writedata;
                if (bus.read !== 1'b0) wr_with_read = 1'b1;
            end
            @(negedge clk);
            #1;
        end
        bad = 0;
        foreach (ram[i]) if (ram[i] !== exp_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s memory: got %0d differing words, want 0", name, bad);
        end
        $display("%s: %0d model cycles, %0d running cycles, %0d writes", name, exp_q.size(), cycles, n_wr);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] instr;
        logic [15:0] b;
        logic [15:0] exp_store;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int          cyc;
        int          nw;
        logic [11:0] wa;
        logic [15:0] wd;
        logic        wrd;
        bit          h;

        // Program: 0 LDA 040; 1 <instr>; 2 STA 042; 3 STP; 020 LDA 043; 021 STA 042; 022 STP.
        vecs[0]  = '{"add_wrap",  16'hFFFF, 16'h2041, 16'h0002, 16'h0001, 10};
        vecs[1]  = '{"sub_wrap",  16'h0001, 16'h3041, 16'h0002, 16'hFFFF, 10};
        vecs[2]  = '{"add",       16'h1234, 16'h2041, 16'h1111, 16'h2345, 10};
        vecs[3]  = '{"add_ovf",   16'h8000, 16'h2041, 16'h8000, 16'h0000, 10};
        vecs[4]  = '{"lda",       16'h0000, 16'h0041, 16'hCAFE, 16'hCAFE, 10};
        vecs[5]  = '{"sub",       16'h0010, 16'h3041, 16'h0001, 16'h000F, 10};
        vecs[6]  = '{"jge_nt",    16'h8000, 16'h5020, 16'h0000, 16'h8000, 9};
        vecs[7]  = '{"jge_t",     16'h7FFF, 16'h5020, 16'h0000, 16'h5555, 12};
        vecs[8]  = '{"jne_nt",    16'h0000, 16'h6020, 16'h0000, 16'h0000, 9};
        vecs[9]  = '{"jne_t",     16'h0001, 16'h6020, 16'h0000, 16'h5555, 12};
        vecs[10] = '{"jmp",       16'h1234, 16'h4020, 16'h0000, 16'h5555, 12};
        vecs[11] = '{"nop9",      16'h4321, 16'h9ABC, 16'h0000, 16'h4321, 9};
        vecs[12] = '{"nopF",      16'h0F0F, 16'hF000, 16'h0000, 16'h0F0F, 9};
`ifdef MU0_LDI_EN
        vecs[13] = '{"op8_ldi",   16'h4321, 16'h8041, 16'h0000, 16'h0041, 9};
`else
        vecs[13] = '{"op8_nop",   16'h4321, 16'h8041, 16'h0000, 16'h4321, 9};
`endif

        for (int v = 0; v < 14; v++) begin
            clear_img();
            img[12'h000] = 16'h0040;
            img[12'h001] = vecs[v].instr;
            img[12'h002] = 16'h1042;
            img[12'h003] = 16'h7000;
            img[12'h020] = 16'h0043;
            img[12'h021] = 16'h1042;
            img[12'h022] = 16'h7000;
            img[12'h040] = vecs[v].a;
            img[12'h041] = vecs[v].b;
            img[12'h042] = 16'hDEAD;
            img[12'h043] = 16'h5555;
            run_prog(vecs[v].name, cyc, nw, wa, wd, wrd);
            check({vecs[v].name, "_store"}, {16'h0, ram[12'h042]}, {16'h0, vecs[v].exp_store});
            check({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cycles);
        end

        // Countdown loop from the lab handout.
        clear_img();
        img[0] = 16'h0005; img[1] = 16'h3006; img[2] = 16'h6001; img[3] = 16'h1007;
        img[4] = 16'h7000; img[5] = 16'h0003; img[6] = 16'h0001; img[7] = 16'hFFFF;
        run_prog("countdown", cyc, nw, wa, wd, wrd);
        check("countdown_cycles", cyc, 22);
        check("countdown_mem7", {16'h0, ram[7]}, 32'h0);

        // STA handshake: a single write strobe carrying ACC.
        clear_img();
        img[0] = 16'h0040; img[1] = 16'h1100; img[2] = 16'h7000; img[12'h040] = 16'hBEEF;
        run_prog("sta", cyc, nw, wa, wd, wrd);
        check("sta_write_cycles", nw, 1);
        check("sta_address", {20'h0, wa}, 32'h100);
        check("sta_writedata", {16'h0, wd}, 32'hBEEF);
        check("sta_no_read", {31'h0, wrd}, 32'h0);

        // STP at the top of memory, then nothing on the bus.
        clear_img();
        img[0] = 16'h4FFF; img[12'hFFF] = 16'h7000;
        run_prog("halt_fff", cyc, nw, wa, wd, wrd);
        check("halt_fff_cycles", cyc, 4);
        nw = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.read !== 1'b0 || bus.write !== 1'b0 || running !== 1'b0) nw++;
            @(negedge clk);
            #1;
        end
        check("halt_quiet", nw, 0);

        // NOP at 0xFFF wraps to 0; the second pass through 0 takes JNE to the STP.
        clear_img();
        img[0] = 16'h6003; img[1] = 16'h0010; img[2] = 16'h4FFF; img[3] = 16'h7000;
        img[12'h010] = 16'h0001; img[12'hFFF] = 16'h9000;
        run_prog("nop_wrap", cyc, nw, wa, wd, wrd);
        check("nop_wrap_cycles", cyc, 13);

        // Reset while STA is in EXEC: the write is dropped immediately.
        clear_img();
        img[0] = 16'h1100; img[1] = 16'h7000; img[12'h100] = 16'h1234;
        load_and_reset();
        @(posedge clk);
        #1;
        check("midrst_pre_write", {31'h0, bus.write}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_strobes", {30'h0, bus.read, bus.write}, 32'h0);
        check("midrst_running", {31'h0, running}, 32'h1);
        @(posedge clk);
        #1;
        check("midrst_mem", {16'h0, ram[12'h100]}, 32'h1234);
        $display("midrst: reset during STA EXEC");

        // Random programs that the model confirms will halt.
        for (int p = 0; p < 12; p++) begin
            logic [3:0] op;
            h = 1'b0;
            for (int t = 0; t < 20 && !h; t++) begin
                clear_img();
                for (int i = 0; i < 32; i++) begin
                    op = 4'($urandom_range(0, 9));
                    if (op == 4'h4 || op == 4'h5 || op == 4'h6)
                        img[i] = {op, 12'($urandom_range(0, 31))};
                    else
                        img[i] = {op, 12'($urandom_range(0, 63))};
                end
                for (int i = 32; i < 64; i++) img[i] = 16'($urandom);
                model_run(h);
            end
            if (h) run_prog($sformatf("random%0d", p), cyc, nw, wa, wd, wrd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
